// File: rtl/prog_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// prog_mem_responder_pkg
//   Shared definitions for the program-memory responder and the CPU core:
//   control state encodings, the NOP opcode used to fill memory on clear,
//   and the default program-memory address width.
// ----------------------------------------------------------------------------
package prog_mem_responder_pkg;

    // Default program-memory address width (DEPTH = 2**ADDR_BITS bytes).
    localparam int unsigned ADDR_BITS_DEFAULT = 10;

    // NOP opcode of the CPU core; memory is flooded with it after reset.
    localparam logic [7:0] NOP_OPCODE = 8'hEA;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } pm_state_t;

endpackage : prog_mem_responder_pkg

// File: rtl/prog_mem_responder_byte_ram.sv
// ----------------------------------------------------------------------------
// byte_ram
//   DEPTH x 8 single-clock RAM with one synchronous write port and one
//   registered read port. Contents are never reset, so the array maps onto
//   block RAM.
//
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled on the rising edge
//   rdata  out  registered read data (one-cycle latency)
// ----------------------------------------------------------------------------
module byte_ram #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule : byte_ram

// File: rtl/prog_mem_responder.sv
// ----------------------------------------------------------------------------
// prog_mem_responder
//   Program memory for a small CPU core. After reset the memory is flooded
//   with FILL_BYTE (CLEAR), then the CPU is released and reads it with a
//   one-cycle latency (RUN). A byte-stream loader can replace the program at
//   any time from RUN (LOAD); the CPU is held in reset while loading.
//
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous, active-high reset
//   cpu_addr    in   CPU address bus (upper bits ignored, memory mirrors)
//   cpu_din     out  read data to the CPU, 8'h00 outside RUN
//   cpu_reset   out  reset to the CPU core, high in CLEAR and LOAD
//   ld_start    in   pulse: begin (or restart) a program load
//   ld_valid    in   loader byte valid
//   ld_data     in   loader byte
//   ld_ready    out  loader byte accepted this cycle (high in LOAD)
//   ld_done     in   pulse: end the load
//   busy        out  high in CLEAR or LOAD
//   load_count  out  bytes accepted in the current or last load (saturating)
// ----------------------------------------------------------------------------
module prog_mem_responder
    import prog_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT,
    parameter logic [7:0]  FILL_BYTE = NOP_OPCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    output logic [7:0]  cpu_din,
    output logic        cpu_reset,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        ld_done,
    output logic        busy,
    output logic [15:0] load_count
);

    localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);
    localparam logic [15:0]          COUNT_ONE = 16'd1;

    // Registered state
    pm_state_t              state_q,      state_d;
    logic [ADDR_BITS-1:0]   ptr_q,        ptr_d;
    logic [15:0]            load_count_q, load_count_d;
    logic                   cpu_reset_q,  cpu_reset_d;
    logic                   ld_ready_q,   ld_ready_d;
    logic                   busy_q,       busy_d;
    logic                   rd_valid_q,   rd_valid_d;

    // RAM port signals
    logic                   ram_we;
    logic [ADDR_BITS-1:0]   ram_waddr;
    logic [7:0]             ram_wdata;
    logic [7:0]             ram_rdata;

    // Upper address bits are deliberately ignored (memory mirrors).
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[15:ADDR_BITS];

    // ------------------------------------------------------------------
    // Next-state and write-port logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        ram_we       = 1'b0;
        ram_waddr    = ptr_q;
        ram_wdata    = FILL_BYTE;

        unique case (state_q)
            ST_CLEAR: begin
                // Loader inputs are ignored while clearing.
                ram_we = 1'b1;
                if (ptr_q == '1) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end

            ST_RUN: begin
                if (ld_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = '0;
                    load_count_d = '0;
                end
            end

            ST_LOAD: begin
                ram_wdata = ld_data;
                if (ld_start) begin
                    // Restart wins over both a same-cycle byte and ld_done.
                    ptr_d        = '0;
                    load_count_d = '0;
                end else begin
                    if (ld_valid && ld_ready_q) begin
                        ram_we = 1'b1;
                        ptr_d  = ptr_q + PTR_ONE;
                        if (load_count_q != '1) begin
                            load_count_d = load_count_q + COUNT_ONE;
                        end
                    end
                    if (ld_done) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = (state_d != ST_RUN);
        ld_ready_d  = (state_d == ST_LOAD);
        rd_valid_d  = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            load_count_q <= '0;
            cpu_reset_q  <= 1'b1;
            ld_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_count_q <= load_count_d;
            cpu_reset_q  <= cpu_reset_d;
            ld_ready_q   <= ld_ready_d;
            busy_q       <= busy_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    byte_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_byte_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (cpu_addr[ADDR_BITS-1:0]),
        .rdata (ram_rdata)
    );

    // The RAM read register cannot be reset, so a resettable valid flag,
    // captured on the same edge, forces cpu_din to zero outside RUN.
    assign cpu_din    = rd_valid_q ? ram_rdata : 8'h00;
    assign cpu_reset  = cpu_reset_q;
    assign ld_ready   = ld_ready_q;
    assign busy       = busy_q;
    assign load_count = load_count_q;

endmodule : prog_mem_responder

// File: tb/tb_prog_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_prog_mem_responder
//   Self-checking bench for prog_mem_responder. A reference memory array
//   tracks every accepted loader byte; each CPU read pushes the expected
//   byte into a scoreboard queue, which is popped when the DUT's registered
//   read data appears one cycle later.
// ----------------------------------------------------------------------------
module tb_prog_mem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_reset;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        busy;
    logic [15:0] load_count;

    prog_mem_responder #(
        .ADDR_BITS (10),
        .FILL_BYTE (8'hEA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_reset  (cpu_reset),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .busy       (busy),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [7:0]  model_mem [DEPTH];
    int unsigned model_ptr;
    int unsigned model_count;
    logic [7:0]  exp_q [$];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic cpu_read(input logic [15:0] addr, input string tag);
        logic [9:0] a;
        logic [7:0] exp;
        a        = addr[9:0];
        cpu_addr = addr;
        exp_q.push_back(model_mem[a]);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, {24'h0, cpu_din}, {24'h0, exp});
        @(negedge clk);
    endtask

    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hEA;
        model_ptr   = 0;
        model_count = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        model_mem[model_ptr] = b;
        model_ptr            = (model_ptr + 1) % DEPTH;
        if (model_count != 32'hFFFF) model_count++;
    endtask

    // Start pulse from RUN; afterwards the DUT is in LOAD.
    task automatic load_begin();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start    = 1'b0;
        model_ptr   = 0;
        model_count = 0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        @(negedge clk);
        ld_valid = 1'b0;
        model_accept(b);
    endtask

    task automatic load_end();
        ld_done = 1'b1;
        check("cpu_reset_at_done", {31'h0, cpu_reset}, 32'd1);
        @(negedge clk);
        ld_done = 1'b0;
        check("cpu_reset_after_done", {31'h0, cpu_reset}, 32'd0);
    endtask

    // Runs the 1024-cycle clear from a just-released reset.
    task automatic run_clear(input string tag, input bit start_at_end);
        int unsigned bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(busy && cpu_reset && !ld_ready && cpu_din == 8'h00)) bad++;
            if (start_at_end && i == DEPTH - 1) begin
                ld_start = 1'b1;
                ld_valid = 1'b1;
                ld_data  = 8'h77;
            end
            @(negedge clk);
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
        check({tag, "_busy_throughout"}, bad, 32'd0);
        check({tag, "_busy_done"}, {31'h0, busy}, 32'd0);
        check({tag, "_cpu_reset_done"}, {31'h0, cpu_reset}, 32'd0);
        check({tag, "_ld_ready_run"}, {31'h0, ld_ready}, 32'd0);
        model_fill();
    endtask

    initial begin
        reset    = 1'b1;
        cpu_addr = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_done  = 1'b0;
        model_fill();

        // Reset values, sampled before any clock edge.
        #3;
        check("rst_cpu_din",    {24'h0, cpu_din}, 32'h0);
        check("rst_cpu_reset",  {31'h0, cpu_reset}, 32'd1);
        check("rst_ld_ready",   {31'h0, ld_ready}, 32'd0);
        check("rst_busy",       {31'h0, busy}, 32'd1);
        check("rst_load_count", {16'h0, load_count}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        // ld_start (with a byte) on the final CLEAR cycle must be ignored.
        run_clear("clear", 1'b1);
        cpu_read(16'h0123, "rd_fill_0123");
        cpu_read(16'h03FF, "rd_fill_03ff");

        // Basic four-byte load.
        load_begin();
        check("load_ready",     {31'h0, ld_ready}, 32'd1);
        check("load_busy",      {31'h0, busy}, 32'd1);
        check("load_cpu_din",   {24'h0, cpu_din}, 32'h0);
        load_byte(8'hA9);
        load_byte(8'h05);
        load_byte(8'h69);
        load_byte(8'h03);
        load_end();
        check("load4_count", {16'h0, load_count}, model_count);
        for (int i = 0; i < 4; i++) cpu_read(16'(i), "rd_load4");
        cpu_read(16'hF400, "rd_mirror_f400");
        cpu_read(16'h0000, "rd_mirror_0000");

        // 1026-byte load wraps and overwrites addresses 0 and 1.
        load_begin();
        for (int i = 0; i < 1026; i++) load_byte(8'(i));
        load_end();
        check("wrap_count", {16'h0, load_count}, 32'd1026);
        cpu_read(16'h0000, "rd_wrap_0");
        cpu_read(16'h0001, "rd_wrap_1");
        cpu_read(16'h03FF, "rd_wrap_3ff");
        cpu_read(16'h0200, "rd_wrap_200");

        // Last byte together with ld_done.
        load_begin();
        load_byte(8'h11);
        load_byte(8'h22);
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        ld_done  = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        model_accept(8'h55);
        check("done_byte_count", {16'h0, load_count}, model_count);
        check("done_byte_run",   {31'h0, ld_ready}, 32'd0);
        check("done_byte_cpurst", {31'h0, cpu_reset}, 32'd0);
        cpu_read(16'h0002, "rd_done_byte");

        // Restart inside LOAD drops the concurrent byte; start beats done.
        load_begin();
        load_byte(8'h31);
        load_byte(8'h32);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h99;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        model_ptr   = 0;
        model_count = 0;
        check("restart_count", {16'h0, load_count}, 32'd0);
        load_byte(8'h44);
        ld_start = 1'b1;
        ld_done  = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_done  = 1'b0;
        model_ptr   = 0;
        model_count = 0;
        check("start_beats_done_ready", {31'h0, ld_ready}, 32'd1);
        check("start_beats_done_count", {16'h0, load_count}, 32'd0);
        load_byte(8'h66);
        load_end();
        check("restart_final_count", {16'h0, load_count}, model_count);
        cpu_read(16'h0000, "rd_restart_0");
        cpu_read(16'h0001, "rd_restart_1");

        // Bytes offered in RUN are discarded; load_count holds.
        ld_valid = 1'b1;
        ld_data  = 8'hDD;
        @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        check("run_hold_count", {16'h0, load_count}, model_count);
        cpu_read(16'h0000, "rd_run_discard_0");
        cpu_read(16'h0001, "rd_run_discard_1");

        // Reset in the middle of a load.
        load_begin();
        load_byte(8'hC1);
        load_byte(8'hC2);
        load_byte(8'hC3);
        check("mid_count", {16'h0, load_count}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_count",    {16'h0, load_count}, 32'd0);
        check("midrst_ready",    {31'h0, ld_ready}, 32'd0);
        check("midrst_cpu_din",  {24'h0, cpu_din}, 32'h0);
        check("midrst_busy",     {31'h0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_clear("reclear", 1'b0);
        check("reclear_count", {16'h0, load_count}, 32'd0);
        cpu_read(16'h0000, "rd_reclear_0");
        cpu_read(16'h0002, "rd_reclear_2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_prog_mem_responder

// File: doc/prog_mem_responder.md
PROG_MEM_RESPONDER -- requirements
Module: prog_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, SHALL set memory depth DEPTH = 2**ADDR_BITS bytes.
REQ-002 Parameter FILL_BYTE, default 8'hEA (NOP), SHALL be the value written to every location during clear.
REQ-003 clk  in  1  clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_addr  in  16  CPU address bus.
REQ-006 cpu_din  out  8  read data returned to the CPU data input.
REQ-007 cpu_reset  out  1  active-high reset driven to the CPU core.
REQ-008 ld_start  in  1  one-cycle pulse that requests a program load.
REQ-009 ld_valid  in  1  loader byte valid.
REQ-010 ld_data  in  8  loader byte.
REQ-011 ld_ready  out  1  block accepts a loader byte this cycle.
REQ-012 ld_done  in  1  one-cycle pulse that ends the load.
REQ-013 busy  out  1  high in CLEAR or LOAD.
REQ-014 load_count  out  16  bytes accepted in the current or last load.

Function
REQ-015 The state machine SHALL have three states: CLEAR, RUN and LOAD.
REQ-016 CLEAR: one FILL_BYTE write per cycle at ptr = 0..DEPTH-1; after the write at DEPTH-1 the state SHALL go to RUN and ptr SHALL return to 0.
REQ-017 CLEAR SHALL last exactly DEPTH cycles; ld_start, ld_valid and ld_done SHALL be ignored in CLEAR.
REQ-018 RUN: every edge SHALL register cpu_din <= mem[cpu_addr[ADDR_BITS-1:0]], giving 1-cycle read latency.
REQ-019 Upper address bits SHALL be ignored, so addresses mirror modulo DEPTH.
REQ-020 In CLEAR and LOAD, cpu_din SHALL read 8'h00.
REQ-021 RUN with ld_start=1: next state SHALL be LOAD, with ptr=0 and load_count=0.
REQ-022 LOAD: ld_ready SHALL be 1.
REQ-023 In LOAD, ld_valid&&ld_ready SHALL write ld_data to mem[ptr], increment ptr (wrapping DEPTH-1 -> 0) and increment load_count (saturating at 16'hFFFF).
REQ-024 In LOAD, ld_done=1 SHALL return the state to RUN on the next edge.
REQ-025 If ld_valid and ld_done are high in the same cycle, the byte SHALL still be written and counted before the return to RUN.
REQ-026 In LOAD, ld_start=1 SHALL restart the load: ptr=0 and load_count=0, and any byte presented in the same cycle SHALL be dropped.
REQ-027 If ld_start and ld_done are high in the same cycle in LOAD, ld_start SHALL win and the state SHALL stay LOAD.
REQ-028 cpu_reset SHALL be 1 in CLEAR and LOAD and 0 in RUN, registered so it changes on the same edge as the state.
REQ-029 ld_ready SHALL be 0 outside LOAD, and bytes offered outside LOAD SHALL be discarded.
REQ-030 load_count SHALL hold its value in RUN.

Reset
REQ-031 On reset assertion, without waiting for clk: state=CLEAR, ptr=0, cpu_din=8'h00, cpu_reset=1, ld_ready=0, busy=1, load_count=0.
REQ-032 Memory contents SHALL NOT be reset directly; they are initialised only by CLEAR.
REQ-033 Reset asserted during LOAD SHALL abort the load and restart CLEAR from ptr 0.

Structure
REQ-034 A shared package SHALL hold the state encodings, the NOP opcode constant 8'hEA and the ADDR_BITS default, shared with the CPU core.
REQ-035 Storage SHALL be a sub-module byte_ram: DEPTH x 8, one synchronous write port, one registered read port, inferrable as block RAM.
REQ-036 The control FSM, ptr and load_count SHALL live in prog_mem_responder.

Verification
REQ-037 Reset, then 1024 cycles of CLEAR -> busy=1 and cpu_reset=1 throughout; RUN entered on cycle 1024; cpu_addr=16'h0123 -> cpu_din=8'hEA one cycle later.
REQ-038 ld_start, then bytes A9,05,69,03 with ld_valid, then ld_done -> load_count=4, cpu_reset falls one cycle after ld_done, and reading addr 0..3 returns A9,05,69,03.
REQ-039 Load 1026 bytes with value = index[7:0] -> mem[0]=8'h00 and mem[1]=8'h01 (wrap overwrite), mem[1023]=8'hFF, load_count=1026.
REQ-040 Last byte 8'h55 with ld_valid and ld_done in the same cycle -> byte stored, count includes it, state RUN.
REQ-041 Issue ld_start in CLEAR -> ignored; reset mid-LOAD after 3 bytes -> CLEAR restarts and load_count=0.
REQ-042 cpu_addr=16'hF400 -> same data as 16'h0000 (mirroring).
